// File: rtl/hilo_mult_sequencer.sv
// Multi-cycle HI/LO multiply unit: radix-2 shift-add over 32 iterations,
// plus single-cycle moves to/from the HI and LO registers.
module hilo_mult_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MFHI  = 5'b10111;
  localparam logic [4:0] OP_MFLO  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [4:0]  op_r;
  logic [4:0]  cnt_r;
  logic        neg_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [63:0] prod_r;

  logic        is_mul_s;
  logic        is_signed_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [63:0] prod_signed_s;
  logic [63:0] hilo_new_s;

  // Opcode decode and operand magnitudes; -2^31 maps to magnitude 2^31.
  always_comb begin
    is_mul_s    = 1'b0;
    is_signed_s = (ALUControl != OP_MULTU);
    a_mag_s     = A;
    b_mag_s     = B;
    case (ALUControl)
      OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB: is_mul_s = 1'b1;
      default:                                     is_mul_s = 1'b0;
    endcase
    if (is_signed_s && A[31]) begin
      a_mag_s = ~A + 32'd1;
    end else begin
      a_mag_s = A;
    end
    if (is_signed_s && B[31]) begin
      b_mag_s = ~B + 32'd1;
    end else begin
      b_mag_s = B;
    end
  end

  // Sign correction and accumulate/subtract into {HI,LO}, wrapping mod 2^64.
  always_comb begin
    prod_signed_s = prod_r;
    hilo_new_s    = prod_r;
    if (neg_r) begin
      prod_signed_s = ~prod_r + 64'd1;
    end else begin
      prod_signed_s = prod_r;
    end
    case (op_r)
      OP_MADD: hilo_new_s = {Hi, Lo} + prod_signed_s;
      OP_MSUB: hilo_new_s = {Hi, Lo} - prod_signed_s;
      default: hilo_new_s = prod_signed_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start && is_mul_s) begin
          next_state_s = ITER;
        end else begin
          next_state_s = IDLE;
        end
      end
      ITER: begin
        if (cnt_r == 5'd31) begin
          next_state_s = FINISH;
        end else begin
          next_state_s = ITER;
        end
      end
      FINISH:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Result   <= 32'd0;
      Hi       <= 32'd0;
      Lo       <= 32'd0;
      op_r     <= 5'd0;
      cnt_r    <= 5'd0;
      neg_r    <= 1'b0;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      prod_r   <= 64'd0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            case (ALUControl)
              OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB: begin
                op_r     <= ALUControl;
                neg_r    <= is_signed_s & (A[31] ^ B[31]);
                mcand_r  <= {32'd0, a_mag_s};
                mplier_r <= b_mag_s;
                prod_r   <= 64'd0;
                cnt_r    <= 5'd0;
                Busy     <= 1'b1;
              end
              OP_MTHI: begin
                Hi   <= A;
                Done <= 1'b1;
              end
              OP_MTLO: begin
                Lo   <= A;
                Done <= 1'b1;
              end
              OP_MFHI: begin
                Result <= Hi;
                Done   <= 1'b1;
              end
              OP_MFLO: begin
                Result <= Lo;
                Done   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ITER: begin
          if (mplier_r[0]) begin
            prod_r <= prod_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 5'd1;
        end
        FINISH: begin
          if (op_r == OP_MUL) begin
            Result <= prod_signed_s[31:0];
          end else begin
            {Hi, Lo} <= hilo_new_s;
            Result   <= hilo_new_s[31:0];
          end
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer: a cycle-level reference model built
// on plain 64-bit arithmetic, checked every cycle, plus hand-computed pins.
module tb_hilo_mult_sequencer;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MFHI  = 5'b10111;
  localparam logic [4:0] OP_MFLO  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [4:0]  ALUControl = 5'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  hilo_mult_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a multiply completes 33 edges after acceptance.
  logic [31:0] m_hi, m_lo, m_res, m_a, m_b;
  logic [4:0]  m_op;
  bit          m_busy, m_done;
  int          m_pend;

  always @(posedge Clk) begin
    logic [63:0] p;
    logic [63:0] acc;
    m_done = 1'b0;
    if (!Rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
      m_busy = 1'b0; m_pend = 0;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        if (m_op == OP_MULTU) p = {32'd0, m_a} * {32'd0, m_b};
        else                  p = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
        acc = {m_hi, m_lo};
        case (m_op)
          OP_MUL:  m_res = p[31:0];
          OP_MADD: begin acc = acc + p; {m_hi, m_lo} = acc; m_res = acc[31:0]; end
          OP_MSUB: begin acc = acc - p; {m_hi, m_lo} = acc; m_res = acc[31:0]; end
          default: begin {m_hi, m_lo} = p; m_res = p[31:0]; end
        endcase
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (Start) begin
      case (ALUControl)
        OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB: begin
          m_op = ALUControl; m_a = A; m_b = B; m_pend = 33; m_busy = 1'b1;
        end
        OP_MTHI: begin m_hi = A;      m_done = 1'b1; end
        OP_MTLO: begin m_lo = A;      m_done = 1'b1; end
        OP_MFHI: begin m_res = m_hi;  m_done = 1'b1; end
        OP_MFLO: begin m_res = m_lo;  m_done = 1'b1; end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy",   Busy,   m_busy);
      check("done",   Done,   m_done);
      check("hi",     Hi,     m_hi);
      check("lo",     Lo,     m_lo);
      check("result", Result, m_res);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    tick();
    Start = 1'b0; ALUControl = 5'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 100) begin
      tick();
      n++;
    end
    if (!Done) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: got no Done expected Done within 100 cycles");
    end
  endtask

  initial begin
    int n;
    int dones;
    Rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy", Busy, 1'b0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    check("rst_result", Result, 32'd0);
    Rst = 1'b1;
    tick();

    // Largest unsigned product, latency and Done width.
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_busy", Busy, 1'b1);
    wait_done(n);
    check("multu_latency", n, 33);
    check("multu_hi", Hi, 32'hFFFFFFFE);
    check("multu_lo", Lo, 32'h00000001);
    check("multu_result", Result, 32'h00000001);
    tick();
    check("done_one_cycle", Done, 1'b0);

    issue(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
    wait_done(n);
    check("mult_neg_hi", Hi, 32'hFFFFFFFF);
    check("mult_neg_lo", Lo, 32'hFFFFFFFA);
    tick();
    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done(n);
    check("mult_min_hi", Hi, 32'h40000000);
    check("mult_min_lo", Lo, 32'h00000000);
    tick();

    // Accumulate wrap-around.
    issue(OP_MTHI, 32'd0, 32'd0);
    check("mthi_done", Done, 1'b1);
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MSUB, 32'd2, 32'd3);
    wait_done(n);
    check("msub_hi", Hi, 32'hFFFFFFFF);
    check("msub_lo", Lo, 32'hFFFFFFFF);
    tick();
    issue(OP_MADD, 32'd1, 32'd1);
    wait_done(n);
    check("madd_hi", Hi, 32'd0);
    check("madd_lo", Lo, 32'd0);
    tick();

    // MUL leaves HI/LO alone; MFHI is single-cycle.
    issue(OP_MTHI, 32'h1234, 32'd0);
    issue(OP_MUL, 32'hFFFFFFFF, 32'd7);
    wait_done(n);
    check("mul_result", Result, 32'hFFFFFFF9);
    check("mul_hi", Hi, 32'h1234);
    tick();
    issue(OP_MFHI, 32'd0, 32'd0);
    check("mfhi_result", Result, 32'h1234);
    check("mfhi_done", Done, 1'b1);
    check("mfhi_busy", Busy, 1'b0);
    tick();

    // Start while busy is ignored.
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (4) tick();
    issue(OP_MTLO, 32'hDEAD, 32'd0);
    wait_done(n);
    check("busy_ignore_latency", n, 28);
    check("busy_ignore_lo", Lo, 32'd15);
    check("busy_ignore_hi", Hi, 32'd0);
    tick();

    // Reset mid-multiply aborts without Done.
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (9) tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check("abort_busy", Busy, 1'b0);
    check("abort_hi", Hi, 32'd0);
    check("abort_lo", Lo, 32'd0);
    dones = 0;
    repeat (40) begin
      tick();
      if (Done) dones++;
    end
    check("abort_no_done", dones, 0);

    // Unsupported code is a no-op.
    issue(OP_MTLO, 32'h55, 32'd0);
    tick();
    issue(OP_ADD, 32'h11, 32'h22);
    check("add_busy", Busy, 1'b0);
    check("add_done", Done, 1'b0);
    check("add_lo", Lo, 32'h55);
    tick();

    // Back-to-back issue in the Done cycle.
    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done(n);
    check("b2b_first_lo", Lo, 32'd6);
    issue(OP_MULTU, 32'h00010000, 32'h00030000);
    check("b2b_accept_busy", Busy, 1'b1);
    wait_done(n);
    check("b2b_latency", n, 33);
    check("b2b_hi", Hi, 32'd3);
    check("b2b_result", Result, 32'd0);
    issue(OP_MFHI, 32'd0, 32'd0);
    check("b2b_mfhi", Result, 32'd3);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_mult_sequencer.md
HILO_MULT_SEQUENCER -- requirements
Module: hilo_mult_sequencer

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits per word and 64 bits for {HI,LO}.
REQ-002 Clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-003 Rst  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-004 Start  input  1  request strobe, sampled on Clk edges while Busy=0.
REQ-005 ALUControl  input  5  operation code, using the team's ALU control encoding.
REQ-006 A  input  32  operand rs, sampled with Start.
REQ-007 B  input  32  operand rt, sampled with Start.
REQ-008 Busy  output  1  multiply in progress; new requests are not accepted.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Result  output  32  registered result word.
REQ-011 Hi  output  32  architectural HI register.
REQ-012 Lo  output  32  architectural LO register.

Function
REQ-013 Supported codes SHALL be:
- MULT=5'b00011: signed, {HI,LO}=A*B.
- MULTU=5'b00100: unsigned, {HI,LO}=A*B.
- MUL=5'b10011: signed; Result=low 32 bits of the product; HI/LO unchanged.
- MADD=5'b10100: signed, {HI,LO}+=A*B.
- MSUB=5'b10101: signed, {HI,LO}-=A*B.
- MFHI=5'b10111, MFLO=5'b11000, MTHI=5'b11001, MTLO=5'b11010.
REQ-014 Any other code with Start=1 SHALL be ignored: no Busy, no Done, no state change.
REQ-015 The FSM SHALL have exactly three states: IDLE, ITER, FINISH. Reset enters IDLE.
REQ-016 In IDLE, Start=1 with a multiply code (MULT, MULTU, MUL, MADD, MSUB) at edge k SHALL:
- capture |A|, |B|, the product sign, and the opcode;
- clear the 64-bit partial product and the 5-bit iteration counter;
- enter ITER with Busy=1 from edge k.
REQ-017 ITER SHALL perform one radix-2 shift-add step per cycle, for exactly 32 cycles (edges k+1..k+32), then enter FINISH.
REQ-018 At edge k+33 (FINISH), the block SHALL:
- apply two's-complement sign correction;
- write {HI,LO} per REQ-013;
- set Result to the new LO (MUL: the product's low word);
- set Done=1 and Busy=0 for the following cycle;
- return to IDLE.
REQ-019 Multiply latency SHALL therefore be 33 cycles from the Start edge to the Done cycle, and Busy SHALL be 1 for exactly 33 cycles.
REQ-020 Magnitude arithmetic SHALL be 32x32->64 unsigned; -2^31 SHALL be handled correctly (magnitude 2^31).
REQ-021 MADD/MSUB SHALL wrap modulo 2^64 with no overflow flag.
REQ-022 Single-cycle ops in IDLE at edge k SHALL each complete with Done=1 in the next cycle, Busy remaining 0:
- MTHI: HI<=A.
- MTLO: LO<=A.
- MFHI: Result<=HI.
- MFLO: Result<=LO.
REQ-023 Start SHALL be ignored while Busy=1; operands and opcode SHALL NOT be re-sampled.
REQ-024 Start asserted in the Done cycle SHALL be accepted (back-to-back issue); MFHI/MFLO issued then SHALL return the just-written value.
REQ-025 Done SHALL never be high for two consecutive cycles from a single request.
REQ-026 Result, Hi and Lo SHALL hold their values between writes.

Reset
REQ-027 When Rst=0 at an edge, the block SHALL set state=IDLE, Busy=0, Done=0, Result=0, Hi=0, Lo=0, and clear the counter.
REQ-028 Reset SHALL take priority over Start and over any in-flight operation.
REQ-029 An aborted multiply SHALL produce no Done and no HI/LO write.

Verification
REQ-030 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy high for 33 cycles, then Done one cycle, Hi=0xFFFFFFFE, Lo=0x00000001, Result=0x00000001.
REQ-031 MULT A=0xFFFFFFFE B=0x00000003 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. Then MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
REQ-032 MTHI 0, MTLO 5, MSUB A=2 B=3 -> Hi=Lo=0xFFFFFFFF. Then MADD A=1 B=1 -> Hi=Lo=0 (carry wraps).
REQ-033 MTHI 0x1234, then MUL A=0xFFFFFFFF B=7 -> Result=0xFFFFFFF9, Hi=0x1234. Then MFHI -> Result=0x1234, Done one cycle after Start, Busy never high.
REQ-034 MULT issued, then Start with MTLO during cycle 5 of ITER -> ignored, Lo unchanged by the MTLO. Rst=0 at cycle 10 of a second MULT -> Busy=0, Hi=Lo=0, no Done.
REQ-035 Start with ALUControl=5'b00000 (ADD) -> Busy and Done stay 0, Hi/Lo/Result unchanged. Back-to-back MULTU issued in the Done cycle -> accepted, second Done exactly 33 cycles later.
